// File: rtl/ctx_mem_arbiter.sv
// Data-memory OBI arbiter between the cv32e40p data port and the RTOS context store/load ports.
// Grants are tagged in a small FIFO so in-order responses are routed back to their issuer.
module ctx_mem_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned STARVE_LIMIT    = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        core_req_i,
   output logic        core_gnt_o,
   output logic        core_rvalid_o,
   input  logic        core_we_i,
   input  logic [3:0]  core_be_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wdata_i,
   output logic [31:0] core_rdata_o,
   input  logic        ctx_wr_rdy_i,
   input  logic [63:0] ctx_wr_i,
   output logic        ctx_wr_en_o,
   input  logic        ctx_rd_addr_rdy_i,
   input  logic [31:0] ctx_rd_addr_i,
   output logic        ctx_rd_addr_en_o,
   output logic        ctx_rd_data_en_o,
   output logic [31:0] ctx_rd_data_o,
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   output logic        err_o
);

   localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned StvW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {SrcCore = 2'd0, SrcCtxw = 2'd1, SrcCtxr = 2'd2} src_e;

   src_e            sel_q, sel_d, win, head;
   logic            lock_q, lock_d;
   logic [CntW-1:0] count_q, count_d;
   logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [StvW-1:0] starve_q, starve_d;
   logic            err_q, err_d;
   logic [1:0]      tags_q [MAX_OUTSTANDING];
   logic            ctx_pend, full, any_req, src_req, gnt, push, pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign ctx_pend = ctx_wr_rdy_i | ctx_rd_addr_rdy_i;
   assign full     = (count_q == CntW'(MAX_OUTSTANDING));

   always_comb begin
      win     = SrcCore;
      any_req = 1'b0;
      if (lock_q) begin
         win     = sel_q;
         any_req = 1'b1;
      end else if (core_req_i && !((starve_q == StvW'(STARVE_LIMIT)) && ctx_pend)) begin
         win     = SrcCore;
         any_req = 1'b1;
      end else if (ctx_wr_rdy_i) begin
         win     = SrcCtxw;
         any_req = 1'b1;
      end else if (ctx_rd_addr_rdy_i) begin
         win     = SrcCtxr;
         any_req = 1'b1;
      end
   end

   // A locked transfer is already committed, so it bypasses the full check.
   assign mem_req_o = lock_q | (any_req & ~full);
   assign gnt       = mem_req_o & mem_gnt_i;
   assign push      = gnt;
   assign pop       = mem_rvalid_i & (count_q != '0);
   assign head      = src_e'(tags_q[rptr_q]);

   always_comb begin
      src_req     = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_addr_o  = 32'h0;
      mem_wdata_o = 32'h0;
      unique case (win)
         SrcCore: src_req = core_req_i;
         SrcCtxw: src_req = ctx_wr_rdy_i;
         SrcCtxr: src_req = ctx_rd_addr_rdy_i;
         default: src_req = 1'b0;
      endcase
      if (mem_req_o) begin
         unique case (win)
            SrcCore: begin
               mem_we_o    = core_we_i;
               mem_be_o    = core_be_i;
               mem_addr_o  = core_addr_i;
               mem_wdata_o = core_wdata_i;
            end
            SrcCtxw: begin
               mem_we_o    = 1'b1;
               mem_be_o    = 4'hF;
               mem_addr_o  = ctx_wr_i[63:32];
               mem_wdata_o = ctx_wr_i[31:0];
            end
            SrcCtxr: begin
               mem_be_o    = 4'hF;
               mem_addr_o  = ctx_rd_addr_i;
            end
            default: ;
         endcase
      end
   end

   assign core_gnt_o       = gnt & (win == SrcCore);
   assign ctx_wr_en_o      = gnt & (win == SrcCtxw);
   assign ctx_rd_addr_en_o = gnt & (win == SrcCtxr);
   assign core_rvalid_o    = pop & (head == SrcCore);
   assign ctx_rd_data_en_o = pop & (head == SrcCtxr);
   assign core_rdata_o     = core_rvalid_o ? mem_rdata_i : 32'h0;
   assign ctx_rd_data_o    = ctx_rd_data_en_o ? mem_rdata_i : 32'h0;
   assign err_o            = err_q;

   always_comb begin
      lock_d   = lock_q;
      sel_d    = sel_q;
      wptr_d   = push ? ptr_inc(wptr_q) : wptr_q;
      rptr_d   = pop ? ptr_inc(rptr_q) : rptr_q;
      count_d  = count_q;
      starve_d = starve_q;
      err_d    = err_q | (mem_rvalid_i & (count_q == '0)) | (lock_q & ~src_req);
      if (gnt) begin
         lock_d = 1'b0;
      end else if (mem_req_o) begin
         lock_d = 1'b1;
         sel_d  = win;
      end
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CntW'(1);
      end
      if (!ctx_pend || (gnt && win != SrcCore)) begin
         starve_d = '0;
      end else if (gnt && starve_q != StvW'(STARVE_LIMIT)) begin
         starve_d = starve_q + StvW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_q   <= 1'b0;
         sel_q    <= SrcCore;
         count_q  <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         starve_q <= '0;
         err_q    <= 1'b0;
         for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
            tags_q[i] <= 2'd0;
         end
      end else begin
         lock_q   <= lock_d;
         sel_q    <= sel_d;
         count_q  <= count_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         starve_q <= starve_d;
         err_q    <= err_d;
         if (push) begin
            tags_q[wptr_q] <= win;
         end
      end
   end

endmodule

// File: tb/tb_ctx_mem_arbiter.sv
// Directed bench for ctx_mem_arbiter: a small memory model answers in grant order and a
// scoreboard holds the expected routing/data of every granted transaction.
module tb_ctx_mem_arbiter;

   localparam logic [1:0] T_CORE = 2'd0;
   localparam logic [1:0] T_CTXW = 2'd1;
   localparam logic [1:0] T_CTXR = 2'd2;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        core_req_i = 1'b0, core_we_i = 1'b0;
   logic [3:0]  core_be_i = 4'h0;
   logic [31:0] core_addr_i = '0, core_wdata_i = '0;
   logic        core_gnt_o, core_rvalid_o;
   logic [31:0] core_rdata_o;
   logic        ctx_wr_rdy_i = 1'b0;
   logic [63:0] ctx_wr_i = '0;
   logic        ctx_wr_en_o;
   logic        ctx_rd_addr_rdy_i = 1'b0;
   logic [31:0] ctx_rd_addr_i = '0;
   logic        ctx_rd_addr_en_o, ctx_rd_data_en_o;
   logic [31:0] ctx_rd_data_o;
   logic        mem_req_o, mem_we_o;
   logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [31:0] mem_rdata_i = '0;
   logic        err_o;

   typedef struct packed {
      logic [1:0]  src;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mq[$];
   int          n_assert = 0;
   int          n_fail = 0;

   always #5 clk_i = ~clk_i;

   ctx_mem_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
      .core_we_i(core_we_i), .core_be_i(core_be_i), .core_addr_i(core_addr_i),
      .core_wdata_i(core_wdata_i), .core_rdata_o(core_rdata_o),
      .ctx_wr_rdy_i(ctx_wr_rdy_i), .ctx_wr_i(ctx_wr_i), .ctx_wr_en_o(ctx_wr_en_o),
      .ctx_rd_addr_rdy_i(ctx_rd_addr_rdy_i), .ctx_rd_addr_i(ctx_rd_addr_i),
      .ctx_rd_addr_en_o(ctx_rd_addr_en_o), .ctx_rd_data_en_o(ctx_rd_data_en_o),
      .ctx_rd_data_o(ctx_rd_data_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
   );

   // Memory model: latches the address of every accepted request, answers in order.
   always @(posedge clk_i) begin
      if (rst_ni && mem_req_o && mem_gnt_i) mq.push_back(mem_addr_o);
   end

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clr();
      core_req_i = 1'b0; ctx_wr_rdy_i = 1'b0; ctx_rd_addr_rdy_i = 1'b0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'hFFFF_FFFF;
   endtask

   task automatic drive_rsp();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h0BAD_0000;
      if (mq.size() != 0) mem_rdata_i = mdata(mq.pop_front());
   endtask

   task automatic check_rsp();
      exp_t e;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      chk("core_rvalid", 32'(core_rvalid_o), 32'(e.src == T_CORE));
      chk("core_rdata", core_rdata_o, (e.src == T_CORE) ? e.data : 32'h0);
      chk("ctx_rd_en", 32'(ctx_rd_data_en_o), 32'(e.src == T_CTXR));
      chk("ctx_rd_data", ctx_rd_data_o, (e.src == T_CTXR) ? e.data : 32'h0);
   endtask

   task automatic core_rd(input logic [31:0] a);
      core_req_i = 1'b1; core_we_i = 1'b0; core_be_i = 4'h3; core_addr_i = a;
   endtask

   initial begin
      clr();
      #2;
      chk("rst_mem_req", 32'(mem_req_o), 0);
      chk("rst_core_gnt", 32'(core_gnt_o), 0);
      chk("rst_err", 32'(err_o), 0);
      chk("rst_core_rdata", core_rdata_o, 0);
      chk("rst_ctx_rd_data", ctx_rd_data_o, 0);
      #10 rst_ni = 1'b1;
      tick();

      // Core-only back-to-back reads
      core_rd(32'h100); mem_gnt_i = 1'b1;
      #1;
      chk("t1_gnt0", 32'(core_gnt_o), 1);
      chk("t1_addr0", mem_addr_o, 32'h100);
      chk("t1_be0", 32'(mem_be_o), 32'h3);
      chk("t1_rdata_idle", core_rdata_o, 0);
      sb.push_back('{T_CORE, mdata(32'h100)});
      tick();
      core_rd(32'h104); drive_rsp();
      #1;
      chk("t1_gnt1", 32'(core_gnt_o), 1);
      chk("t1_addr1", mem_addr_o, 32'h104);
      check_rsp();
      sb.push_back('{T_CORE, mdata(32'h104)});
      tick();
      clr(); drive_rsp();
      #1;
      check_rsp();
      chk("t1_ctxw_en", 32'(ctx_wr_en_o), 0);
      chk("t1_err", 32'(err_o), 0);
      tick();

      // Starvation bound: four core grants, then the pending context write
      ctx_wr_rdy_i = 1'b1; ctx_wr_i = {32'h2000, 32'hDEAD_BEEF}; mem_gnt_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         core_rd(32'h200 + 32'(4 * i));
         mem_rvalid_i = 1'b0; mem_rdata_i = 32'hFFFF_FFFF;
         if (i > 0) drive_rsp();
         if (i == 5) chk("t2_starve_clr", 32'(dut.starve_q), 0);
         #1;
         if (i > 0) check_rsp();
         if (i == 4) begin
            chk("t2_ctxw_en", 32'(ctx_wr_en_o), 1);
            chk("t2_core_gnt", 32'(core_gnt_o), 0);
            chk("t2_addr", mem_addr_o, 32'h2000);
            chk("t2_we", 32'(mem_we_o), 1);
            chk("t2_be", 32'(mem_be_o), 32'hF);
            chk("t2_wdata", mem_wdata_o, 32'hDEAD_BEEF);
            sb.push_back('{T_CTXW, 32'h0});
         end else begin
            chk("t2_core_gnt", 32'(core_gnt_o), 1);
            chk("t2_ctxw_en", 32'(ctx_wr_en_o), 0);
            sb.push_back('{T_CORE, mdata(32'h200 + 32'(4 * i))});
         end
         tick();
      end
      clr(); drive_rsp();
      #1;
      check_rsp();
      tick();

      // Response routing with delayed rvalid; FIFO full blocks issue even during a pop
      clr(); core_rd(32'h400); mem_gnt_i = 1'b1;
      #1;
      chk("t3_core_gnt", 32'(core_gnt_o), 1);
      sb.push_back('{T_CORE, mdata(32'h400)});
      tick();
      clr(); ctx_rd_addr_rdy_i = 1'b1; ctx_rd_addr_i = 32'h3000; mem_gnt_i = 1'b1;
      #1;
      chk("t3_ctxr_en", 32'(ctx_rd_addr_en_o), 1);
      chk("t3_ctxr_we", 32'(mem_we_o), 0);
      chk("t3_ctxr_addr", mem_addr_o, 32'h3000);
      sb.push_back('{T_CTXR, mdata(32'h3000)});
      tick();
      clr(); ctx_wr_rdy_i = 1'b1; ctx_wr_i = {32'h2100, 32'h1111_1111}; mem_gnt_i = 1'b1;
      #1;
      chk("t3_full_req", 32'(mem_req_o), 0);
      chk("t3_full_en", 32'(ctx_wr_en_o), 0);
      tick();
      drive_rsp();
      #1;
      chk("t3_full_pop_req", 32'(mem_req_o), 0);
      check_rsp();
      tick();
      drive_rsp();
      #1;
      check_rsp();
      chk("t3_reissue_en", 32'(ctx_wr_en_o), 1);
      chk("t3_reissue_addr", mem_addr_o, 32'h2100);
      sb.push_back('{T_CTXW, 32'h0});
      tick();
      clr(); drive_rsp();
      #1;
      check_rsp();
      tick();

      // Lock: stalled context read holds the port against a core request
      clr(); ctx_rd_addr_rdy_i = 1'b1; ctx_rd_addr_i = 32'h3000;
      #1;
      chk("t4_req", 32'(mem_req_o), 1);
      tick();
      core_rd(32'h500);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t4_lock_addr", mem_addr_o, 32'h3000);
         chk("t4_lock_core_gnt", 32'(core_gnt_o), 0);
         chk("t4_lock_req", 32'(mem_req_o), 1);
         tick();
      end
      mem_gnt_i = 1'b1;
      #1;
      chk("t4_ctxr_en", 32'(ctx_rd_addr_en_o), 1);
      chk("t4_core_gnt", 32'(core_gnt_o), 0);
      sb.push_back('{T_CTXR, mdata(32'h3000)});
      tick();
      ctx_rd_addr_rdy_i = 1'b0; drive_rsp();
      #1;
      check_rsp();
      chk("t4_core_after", 32'(core_gnt_o), 1);
      chk("t4_core_addr", mem_addr_o, 32'h500);
      sb.push_back('{T_CORE, mdata(32'h500)});
      tick();
      clr(); drive_rsp();
      #1;
      check_rsp();
      chk("t4_err", 32'(err_o), 0);
      tick();

      // Spurious rvalid, then async reset with two outstanding
      clr(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
      #1;
      chk("t5_spur_core", 32'(core_rvalid_o), 0);
      chk("t5_spur_ctx", 32'(ctx_rd_data_en_o), 0);
      chk("t5_spur_data", core_rdata_o, 0);
      tick();
      clr();
      #1;
      chk("t5_err_set", 32'(err_o), 1);
      tick();
      chk("t5_err_sticky", 32'(err_o), 1);
      core_rd(32'h700); mem_gnt_i = 1'b1;
      tick();
      core_rd(32'h704);
      tick();
      #1;
      chk("t5_full_req", 32'(mem_req_o), 0);
      chk("t5_full_gnt", 32'(core_gnt_o), 0);
      #1 rst_ni = 1'b0;
      #1;
      chk("t5_rst_err", 32'(err_o), 0);
      chk("t5_rst_count", 32'(dut.count_q), 0);
      clr(); mq.delete(); sb.delete();
      rst_ni = 1'b1;
      tick();
      core_rd(32'h800); mem_gnt_i = 1'b1;
      #1;
      chk("t5_fresh_gnt", 32'(core_gnt_o), 1);
      sb.push_back('{T_CORE, mdata(32'h800)});
      tick();
      clr(); drive_rsp();
      #1;
      check_rsp();
      chk("t5_fresh_err", 32'(err_o), 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
